mix_columns_serial: RTL and testbench

// - AES MixColumns stage (FIPS 197 5.1.3); sits directly downstream of the ShiftRows stage and consumes its 128-bit output.
// - Column-serial datapath: processes one 32-bit column per cycle, so one block takes 4 compute cycles.
// - Valid/ready handshake on both sides; the output holds its result until the downstream stage takes it.

---
 rtl/aes_pkg.sv | 18 +
 rtl/mix_columns_serial_mix_single_column.sv | 29 ++
 rtl/mix_columns_serial.sv | 132 +++++++++++++
 tb/tb_mix_columns_serial.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns stage.
// Block/column widths, GF(2^8) xtime helper and FSM state encoding.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_COL_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mixcol_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_serial_mix_single_column.sv
// Combinational MixColumns on one 32-bit column.
// Row 0 sits in the column MSB byte.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] s0, s1, s2, s3;
    logic [7:0] x0, x1, x2, x3;

    assign {s0, s1, s2, s3} = col_in;
    assign x0 = xtime(s0);
    assign x1 = xtime(s1);
    assign x2 = xtime(s2);
    assign x3 = xtime(s3);

    // 3b is xtime(b)^b; each row folds one doubled and one tripled term
    always_comb begin
        col_out = {
            x0 ^ (x1 ^ s1) ^ s2 ^ s3,
            s0 ^ x1 ^ (x2 ^ s2) ^ s3,
            s0 ^ s1 ^ x2 ^ (x3 ^ s3),
            (x0 ^ s0) ^ s1 ^ s2 ^ x3
        };
    end

endmodule

// File: rtl/mix_columns_serial.sv
// Column-serial AES MixColumns stage, 4 compute cycles per block.
// Optional MIXCOL_BYPASS_EN adds last_round_in to pass final-round blocks unchanged.
module mix_columns_serial
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLK_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] data_in,
`ifdef MIXCOL_BYPASS_EN
    input  logic              last_round_in,
`endif
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int COL_W = DATA_W / 4;

    if (DATA_W != AES_BLK_W) begin : g_bad_width
        $error("mix_columns_serial: DATA_W must be 128");
    end

    mixcol_state_t          state_q, state_d;
    logic [1:0]             col_cnt_q;
    logic [3:0][COL_W-1:0]  buf_q;
    logic [3:0][COL_W-1:0]  dout_q;
    logic [COL_W-1:0]       col_sel;
    logic [COL_W-1:0]       col_mix;
    logic [COL_W-1:0]       col_res;
    logic                   load;

    // column c lives at packed index 3-c, i.e. ~col_cnt
    assign col_sel  = buf_q[~col_cnt_q];
    assign data_out = dout_q;

    mix_single_column u_mix (
        .col_in  (col_sel),
        .col_out (col_mix)
    );

`ifdef MIXCOL_BYPASS_EN
    logic last_q;

    // final round has no MixColumns: forward the buffered column as is
    assign col_res = last_q ? col_sel : col_mix;

    // capture the bypass flag alongside each accepted block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (load) begin
            last_q <= last_round_in;
        end
    end
`else
    assign col_res = col_mix;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, input-side ready and block load strobe
    always_comb begin
        state_d   = state_q;
        ready_out = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (col_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_out = ready_in;
                if (ready_in) begin
                    if (valid_in) begin
                        load    = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // input buffer, column counter, result register and output valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q     <= '0;
            col_cnt_q <= 2'd0;
            dout_q    <= '0;
            valid_out <= 1'b0;
        end else begin
            if (load) begin
                buf_q     <= data_in;
                col_cnt_q <= 2'd0;
            end
            if (state_q == BUSY) begin
                dout_q[~col_cnt_q] <= col_res;
                col_cnt_q          <= col_cnt_q + 2'd1;
                if (col_cnt_q == 2'd3) begin
                    valid_out <= 1'b1;
                end
            end
            if (state_q == DONE && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed bench for mix_columns_serial.
// Expected values are FIPS-197 vectors or a shift-and-add GF(2^8) model.
module tb_mix_columns_serial;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic         ready_out;
    logic [127:0] data_in;
    logic         last_round_in;
    logic         valid_out;
    logic         ready_in;
    logic [127:0] data_out;

    int n_checks;
    int n_fail;
    int cyc;

    mix_columns_serial dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .data_in       (data_in),
`ifdef MIXCOL_BYPASS_EN
        .last_round_in (last_round_in),
`endif
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .data_out      (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] blk);
        logic [127:0] res;
        logic [7:0]   s [4];
        logic [7:0]   base [4];
        logic [7:0]   r;
        base[0] = 8'h02;
        base[1] = 8'h03;
        base[2] = 8'h01;
        base[3] = 8'h01;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) s[j] = blk[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(base[(j - i + 4) % 4], s[j]);
                res[127-32*c-8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid_out !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
    endtask

    localparam logic [127:0] R1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] CV_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] CV_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic [127:0] blks [8];
    int n;
    int last_cyc;

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        reset = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in = '0;
        last_round_in = 1'b0;

        // reset state
        #2 reset = 1'b1;
        #2;
        check("rst_valid", {127'b0, valid_out}, 128'd0);
        check("rst_data", data_out, 128'd0);
        check("rst_ready", {127'b0, ready_out}, 128'd1);
        tick();
        tick();
        reset = 1'b0;

        // FIPS-197 round-1 vector with exact latency
        data_in = R1_IN;
        valid_in = 1'b1;
        #1;
        check("r1_ready_idle", {127'b0, ready_out}, 128'd1);
        tick();
        valid_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("r1_latency_edge%0d", i), {127'b0, valid_out}, {127'b0, i == 4});
        end
        check("r1_data", data_out, R1_OUT);
        tick();
        check("r1_valid_drop", {127'b0, valid_out}, 128'd0);
        check("idle_hold_data", data_out, R1_OUT);

        // single-column vector under back-pressure
        ready_in = 1'b0;
        data_in = CV_IN;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(n);
        check("cv_latency", n, 4);
        check("cv_data", data_out, CV_OUT);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {127'b0, valid_out}, 128'd1);
            check("bp_data", data_out, CV_OUT);
            check("bp_ready", {127'b0, ready_out}, 128'd0);
        end
        data_in = R1_IN;
        valid_in = 1'b1;
        #1;
        check("bp_ready_blocked", {127'b0, ready_out}, 128'd0);
        ready_in = 1'b1;
        #1;
        check("bp_ready_release", {127'b0, ready_out}, 128'd1);
        tick();
        valid_in = 1'b0;
        check("bp_take_valid", {127'b0, valid_out}, 128'd0);
        check("bp_take_busy", {127'b0, ready_out}, 128'd0);
        wait_valid(n);
        check("bp_next_latency", n, 4);
        check("bp_next_data", data_out, R1_OUT);

        // back-to-back random stream
        for (int k = 0; k < 8; k++) blks[k] = {$urandom, $urandom, $urandom, $urandom};
        data_in = blks[0];
        valid_in = 1'b1;
        tick();
        last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                data_in = blks[k+1];
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            wait_valid(n);
            check($sformatf("stream%0d_latency", k), n, 4);
            check($sformatf("stream%0d_data", k), data_out, mix_model(blks[k]));
            if (k > 0) check($sformatf("stream%0d_period", k), cyc - last_cyc, 5);
            last_cyc = cyc;
            tick();
            check($sformatf("stream%0d_valid_drop", k), {127'b0, valid_out}, 128'd0);
        end

        // reset while BUSY with col_cnt==2
        data_in = R1_IN;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst_valid", {127'b0, valid_out}, 128'd0);
        check("midrst_data", data_out, 128'd0);
        check("midrst_ready", {127'b0, ready_out}, 128'd1);
        #2 reset = 1'b0;
        tick();
        data_in = CV_IN;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(n);
        check("postrst_latency", n, 4);
        check("postrst_data", data_out, CV_OUT);
        tick();

`ifdef MIXCOL_BYPASS_EN
        // final-round bypass then a mixed block
        data_in = R1_IN;
        last_round_in = 1'b1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        last_round_in = 1'b0;
        wait_valid(n);
        check("byp_latency", n, 4);
        check("byp_data", data_out, R1_IN);
        tick();
        data_in = R1_IN;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(n);
        check("byp_off_latency", n, 4);
        check("byp_off_data", data_out, R1_OUT);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
